video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_pkg.sv | 53 +++++
 rtl/video_timing_gen_if.sv | 23 ++
 rtl/video_timing_cfg.sv | 113 +++++++++++
 rtl/video_timing_gen.sv | 146 ++++++++++++++
 tb/tb_video_timing_gen.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared register map, timing-set type and 640x480 defaults
// Contents: CFG_* register indices, timing_t (one complete timing set plus
// EARLY), DEF_* 640x480 constants, blank_len() helper (fp+sync+bp).
package video_pkg;

    localparam int TIMING_W = 16;

    localparam logic [3:0] CFG_H_RES  = 4'd0;
    localparam logic [3:0] CFG_H_FP   = 4'd1;
    localparam logic [3:0] CFG_H_SYNC = 4'd2;
    localparam logic [3:0] CFG_H_BP   = 4'd3;
    localparam logic [3:0] CFG_V_RES  = 4'd4;
    localparam logic [3:0] CFG_V_FP   = 4'd5;
    localparam logic [3:0] CFG_V_SYNC = 4'd6;
    localparam logic [3:0] CFG_V_BP   = 4'd7;
    localparam logic [3:0] CFG_POL    = 4'd8;
    localparam logic [3:0] CFG_EARLY  = 4'd9;

    localparam int DEF_H_RES  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_RES  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam bit DEF_H_POL  = 1'b0;
    localparam bit DEF_V_POL  = 1'b0;

    typedef struct packed {
        logic [TIMING_W-1:0] h_res;
        logic [TIMING_W-1:0] h_fp;
        logic [TIMING_W-1:0] h_sync;
        logic [TIMING_W-1:0] h_bp;
        logic [TIMING_W-1:0] v_res;
        logic [TIMING_W-1:0] v_fp;
        logic [TIMING_W-1:0] v_sync;
        logic [TIMING_W-1:0] v_bp;
        logic [TIMING_W-1:0] early;
        logic                h_pol;
        logic                v_pol;
    } timing_t;

    // Blanking length of one axis; the counter starts this far below zero.
    function automatic logic [TIMING_W+1:0] blank_len(
        input logic [TIMING_W-1:0] fp,
        input logic [TIMING_W-1:0] sync,
        input logic [TIMING_W-1:0] bp
    );
        return {2'b00, fp} + {2'b00, sync} + {2'b00, bp};
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - configuration bus between host and timing generator
// master: drives cfg_we/cfg_addr/cfg_wdata/cfg_commit, sees cfg_pending/cfg_err.
// slave : the timing generator side.
interface video_timing_gen_if #(
    parameter int CORDW = 16
);
    logic             cfg_we;
    logic [3:0]       cfg_addr;
    logic [CORDW-1:0] cfg_wdata;
    logic             cfg_commit;
    logic             cfg_pending;
    logic             cfg_err;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, cfg_commit,
        input  cfg_pending, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, cfg_commit,
        output cfg_pending, cfg_err
    );
endinterface

// File: rtl/video_timing_cfg.sv
// rtl/video_timing_cfg.sv - staging/active timing sets with commit at frame boundary
// In : clk_pix, rst, cfg_we/cfg_addr/cfg_wdata (staging write), cfg_commit,
//      boundary (last pixel of the frame).
// Out: active (set in use), h_sta_nxt/v_sta_nxt (counter restart values for the
//      set in use next cycle), cfg_pending, cfg_err.
module video_timing_cfg
    import video_pkg::*;
#(
    parameter int CORDW  = 16,
    parameter int H_RES  = DEF_H_RES,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_RES  = DEF_V_RES,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter bit H_POL  = DEF_H_POL,
    parameter bit V_POL  = DEF_V_POL
) (
    input  logic                    clk_pix,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [3:0]              cfg_addr,
    input  logic [CORDW-1:0]        cfg_wdata,
    input  logic                    cfg_commit,
    input  logic                    boundary,
    output timing_t                 active,
    output logic signed [CORDW-1:0] h_sta_nxt,
    output logic signed [CORDW-1:0] v_sta_nxt,
    output logic                    cfg_pending,
    output logic                    cfg_err
);

    timing_t             def_set;
    timing_t             stage_q, stage_d;
    timing_t             active_q, active_d;
    logic                pending_q, pending_d;
    logic                err_q, err_d;
    logic                commit_ok;
    logic                apply;
    logic [TIMING_W-1:0] wval;

    always_comb begin
        def_set        = '0;
        def_set.h_res  = TIMING_W'(H_RES);
        def_set.h_fp   = TIMING_W'(H_FP);
        def_set.h_sync = TIMING_W'(H_SYNC);
        def_set.h_bp   = TIMING_W'(H_BP);
        def_set.v_res  = TIMING_W'(V_RES);
        def_set.v_fp   = TIMING_W'(V_FP);
        def_set.v_sync = TIMING_W'(V_SYNC);
        def_set.v_bp   = TIMING_W'(V_BP);
        def_set.h_pol  = H_POL;
        def_set.v_pol  = V_POL;
    end

    assign wval = TIMING_W'(cfg_wdata);

    always_comb begin
        // stage_d already carries a same-cycle write, so a write issued with
        // the commit (or on the boundary cycle) is part of what gets applied.
        stage_d = stage_q;
        if (cfg_we) begin
            case (cfg_addr)
                CFG_H_RES:  stage_d.h_res  = wval;
                CFG_H_FP:   stage_d.h_fp   = wval;
                CFG_H_SYNC: stage_d.h_sync = wval;
                CFG_H_BP:   stage_d.h_bp   = wval;
                CFG_V_RES:  stage_d.v_res  = wval;
                CFG_V_FP:   stage_d.v_fp   = wval;
                CFG_V_SYNC: stage_d.v_sync = wval;
                CFG_V_BP:   stage_d.v_bp   = wval;
                CFG_POL: begin
                    stage_d.h_pol = cfg_wdata[0];
                    stage_d.v_pol = cfg_wdata[1];
                end
                CFG_EARLY:  stage_d.early  = wval;
                default: ;
            endcase
        end

        commit_ok = (stage_d.h_res != '0) && (stage_d.v_res != '0);
        // Only a commit registered before this boundary is applied here.
        apply     = boundary && pending_q;
        active_d  = apply ? stage_d : active_q;
        pending_d = apply ? (cfg_commit && commit_ok)
                          : (pending_q || (cfg_commit && commit_ok));
        err_d     = cfg_commit && !commit_ok;

        h_sta_nxt = -CORDW'(blank_len(active_d.h_fp, active_d.h_sync, active_d.h_bp));
        v_sta_nxt = -CORDW'(blank_len(active_d.v_fp, active_d.v_sync, active_d.v_bp));
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            stage_q   <= def_set;
            active_q  <= def_set;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign active      = active_q;
    assign cfg_pending = pending_q;
    assign cfg_err     = err_q;

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - programmable raster timing generator
// In : clk_pix, rst (sync, active-high), cfg (video_timing_gen_if.slave).
// Out: hsync, vsync, de, frame, line, line_pre, sx, sy; all registered, one
//      cycle behind the internal (x,y) counter.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int CORDW  = 16,
    parameter int H_RES  = DEF_H_RES,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_RES  = DEF_V_RES,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter bit H_POL  = DEF_H_POL,
    parameter bit V_POL  = DEF_V_POL
) (
    input  logic                    clk_pix,
    input  logic                    rst,
    video_timing_gen_if.slave       cfg,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    frame,
    output logic                    line,
    output logic                    line_pre,
    output logic signed [CORDW-1:0] sx,
    output logic signed [CORDW-1:0] sy
);

    localparam logic signed [CORDW-1:0] RST_H_STA = CORDW'(-(H_FP + H_SYNC + H_BP));
    localparam logic signed [CORDW-1:0] RST_V_STA = CORDW'(-(V_FP + V_SYNC + V_BP));

    timing_t                 act;
    logic signed [CORDW-1:0] h_sta_nxt, v_sta_nxt;
    logic                    boundary;

    logic        [CORDW-1:0] h_tot, v_tot, early_cw;
    logic signed [CORDW-1:0] h_sta, hs_sta, hs_end, h_last, pre_x;
    logic signed [CORDW-1:0] v_sta, vs_sta, vs_end, v_last;
    logic                    x_end, y_end;

    logic signed [CORDW-1:0] x_q, x_d, y_q, y_d;
    logic signed [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic frame_q, frame_d, line_q, line_d, line_pre_q, line_pre_d;

    video_timing_cfg #(
        .CORDW(CORDW), .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_POL(H_POL), .V_POL(V_POL)
    ) u_cfg (
        .clk_pix     (clk_pix),
        .rst         (rst),
        .cfg_we      (cfg.cfg_we),
        .cfg_addr    (cfg.cfg_addr),
        .cfg_wdata   (cfg.cfg_wdata),
        .cfg_commit  (cfg.cfg_commit),
        .boundary    (boundary),
        .active      (act),
        .h_sta_nxt   (h_sta_nxt),
        .v_sta_nxt   (v_sta_nxt),
        .cfg_pending (cfg.cfg_pending),
        .cfg_err     (cfg.cfg_err)
    );

    // Derived positions of the set in use this cycle.
    always_comb begin
        h_tot    = CORDW'(blank_len(act.h_fp, act.h_sync, act.h_bp));
        v_tot    = CORDW'(blank_len(act.v_fp, act.v_sync, act.v_bp));
        h_sta    = -h_tot;
        v_sta    = -v_tot;
        hs_sta   = h_sta + CORDW'(act.h_fp);
        hs_end   = hs_sta + CORDW'(act.h_sync);
        vs_sta   = v_sta + CORDW'(act.v_fp);
        vs_end   = vs_sta + CORDW'(act.v_sync);
        h_last   = CORDW'(act.h_res) - CORDW'(1);
        v_last   = CORDW'(act.v_res) - CORDW'(1);
        early_cw = CORDW'(act.early);
        // An EARLY reaching past the blanking start pins to the line start.
        pre_x    = (early_cw > h_tot) ? h_sta : -early_cw;
    end

    // Raster counter; the restart values come from the set that will be in
    // use next cycle, so a frame-boundary switch restarts at the new origin.
    always_comb begin
        x_end    = (x_q == h_last);
        y_end    = (y_q == v_last);
        boundary = x_end && y_end;
        x_d      = x_q + CORDW'(1);
        y_d      = y_q;
        if (x_end) begin
            x_d = h_sta_nxt;
            y_d = y_end ? v_sta_nxt : y_q + CORDW'(1);
        end
    end

    always_comb begin
        hsync_d    = ((x_q > hs_sta) && (x_q <= hs_end)) ? act.h_pol : !act.h_pol;
        vsync_d    = ((y_q > vs_sta) && (y_q <= vs_end)) ? act.v_pol : !act.v_pol;
        de_d       = !x_q[CORDW-1] && !y_q[CORDW-1];
        frame_d    = (x_q == h_sta) && (y_q == v_sta);
        line_d     = (x_q == h_sta) && !y_q[CORDW-1];
        line_pre_d = (x_q == pre_x) && !y_q[CORDW-1];
        sx_d       = x_q;
        sy_d       = y_q;
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            x_q        <= RST_H_STA;
            y_q        <= RST_V_STA;
            sx_q       <= RST_H_STA;
            sy_q       <= RST_V_STA;
            hsync_q    <= !H_POL;
            vsync_q    <= !V_POL;
            de_q       <= 1'b0;
            frame_q    <= 1'b0;
            line_q     <= 1'b0;
            line_pre_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_d;
            frame_q    <= frame_d;
            line_q     <= line_d;
            line_pre_q <= line_pre_d;
        end
    end

    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign de       = de_q;
    assign frame    = frame_q;
    assign line     = line_q;
    assign line_pre = line_pre_q;
    assign sx       = sx_q;
    assign sy       = sy_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen
module tb_video_timing_gen;
    import video_pkg::*;

    localparam int CW = 16;

    logic clk_pix = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_pix = ~clk_pix;

    video_timing_gen_if #(.CORDW(CW)) cfg_if ();

    logic hsync, vsync, de, frame, line, line_pre;
    logic signed [CW-1:0] sx, sy;

    video_timing_gen #(
        .CORDW(CW), .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_RES(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0)
    ) dut (
        .clk_pix  (clk_pix),
        .rst      (rst),
        .cfg      (cfg_if.slave),
        .hsync    (hsync),
        .vsync    (vsync),
        .de       (de),
        .frame    (frame),
        .line     (line),
        .line_pre (line_pre),
        .sx       (sx),
        .sy       (sy)
    );

    // Reference model: sets indexed by register address (8 = POL, 9 = EARLY).
    int stg[10];
    int act[10];
    int mx, my;
    bit mpend, merr;
    logic [39:0] exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cnt_de, cnt_hlo, cnt_hhi, cnt_fr, cnt_ln, cnt_lp, cnt_lp_badx, cnt_lp_ne_ln, cnt_vlo;
    int exp_pre;

    function automatic void load_defaults();
        stg = '{16, 2, 3, 4, 6, 1, 2, 1, 0, 0};
        act = stg;
        mx = -9;
        my = -4;
        mpend = 1'b0;
        merr = 1'b0;
    endfunction

    function automatic void clr_stats();
        cnt_de = 0; cnt_hlo = 0; cnt_hhi = 0; cnt_fr = 0; cnt_ln = 0;
        cnt_lp = 0; cnt_lp_badx = 0; cnt_lp_ne_ln = 0; cnt_vlo = 0;
    endfunction

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: compute what the DUT must show after this edge, advance the
    // model, then compare. Inputs are changed by callers at the falling edge.
    task automatic step();
        logic [39:0] e, got;
        int h_sta, hs_sta, hs_end, v_sta, vs_sta, vs_end, pre;
        bit ok, xend, yend, apply;
        h_sta  = -(act[1] + act[2] + act[3]);
        hs_sta = h_sta + act[1];
        hs_end = hs_sta + act[2];
        v_sta  = -(act[5] + act[6] + act[7]);
        vs_sta = v_sta + act[5];
        vs_end = vs_sta + act[6];
        pre    = (act[9] > -h_sta) ? h_sta : -act[9];
        exp_pre = pre;
        if (rst) begin
            load_defaults();
            e = {1'b1, 1'b1, 6'b0, 16'(-9), 16'(-4)};
        end else begin
            e[39] = (mx > hs_sta && mx <= hs_end) ? act[8][0] : !act[8][0];
            e[38] = (my > vs_sta && my <= vs_end) ? act[8][1] : !act[8][1];
            e[37] = (mx >= 0 && my >= 0);
            e[36] = (mx == h_sta && my == v_sta);
            e[35] = (mx == h_sta && my >= 0);
            e[34] = (my >= 0 && mx == pre);
            e[31:16] = 16'(mx);
            e[15:0]  = 16'(my);
            if (cfg_if.cfg_we && cfg_if.cfg_addr <= 4'd9)
                stg[cfg_if.cfg_addr] = (cfg_if.cfg_addr == 4'd8) ? int'(cfg_if.cfg_wdata & 16'd3)
                                                                 : int'(cfg_if.cfg_wdata);
            ok    = (stg[0] != 0) && (stg[4] != 0);
            xend  = (mx == act[0] - 1);
            yend  = (my == act[4] - 1);
            apply = xend && yend && mpend;
            merr  = cfg_if.cfg_commit && !ok;
            if (apply) begin
                act   = stg;
                mpend = cfg_if.cfg_commit && ok;
            end else begin
                mpend = mpend || (cfg_if.cfg_commit && ok);
            end
            if (xend) begin
                mx = -(act[1] + act[2] + act[3]);
                my = yend ? -(act[5] + act[6] + act[7]) : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        e[33] = mpend;
        e[32] = merr;
        exp_q.push_back(e);
        @(posedge clk_pix);
        #1;
        got = {hsync, vsync, de, frame, line, line_pre, cfg_if.cfg_pending, cfg_if.cfg_err, sx, sy};
        check("cycle", got, exp_q.pop_front());
        cnt_de       += int'(de);
        cnt_hlo      += int'(!hsync);
        cnt_hhi      += int'(hsync);
        cnt_vlo      += int'(!vsync);
        cnt_fr       += int'(frame);
        cnt_ln       += int'(line);
        cnt_lp       += int'(line_pre);
        cnt_lp_badx  += int'(line_pre && (int'(sx) != exp_pre));
        cnt_lp_ne_ln += int'(line_pre != line);
        @(negedge clk_pix);
    endtask

    task automatic wr(input logic [3:0] addr, input int data);
        cfg_if.cfg_we    = 1'b1;
        cfg_if.cfg_addr  = addr;
        cfg_if.cfg_wdata = 16'(data);
        step();
        cfg_if.cfg_we    = 1'b0;
    endtask

    task automatic commit();
        cfg_if.cfg_commit = 1'b1;
        step();
        cfg_if.cfg_commit = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        step();
        while (frame !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        check("wait_frame", 40'(frame), 40'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        cfg_if.cfg_we     = 1'b0;
        cfg_if.cfg_addr   = 4'd0;
        cfg_if.cfg_wdata  = '0;
        cfg_if.cfg_commit = 1'b0;
        load_defaults();
        clr_stats();
        @(negedge clk_pix);

        // Reset state
        run(3);
        check("rst_sx", 40'(sx), 40'(16'(-9)));
        check("rst_sy", 40'(sy), 40'(16'(-4)));
        check("rst_ctl", 40'({hsync, vsync, de, frame, line, line_pre, cfg_if.cfg_err}), 40'b1100000);

        // Defaults: 25 clocks/line, 10 lines, two frames exactly
        rst = 1'b0;
        clr_stats();
        run(500);
        check("def_frames", 40'(cnt_fr), 40'd2);
        check("def_de", 40'(cnt_de), 40'd192);
        check("def_hs_low", 40'(cnt_hlo), 40'd60);
        check("def_vs_low", 40'(cnt_vlo), 40'd100);
        check("def_lines", 40'(cnt_ln), 40'd12);

        // Mid-frame reprogram to 20/3/4/5 x 8/1/2/3, positive syncs
        run(40);
        wr(CFG_H_RES, 20); wr(CFG_H_FP, 3); wr(CFG_H_SYNC, 4); wr(CFG_H_BP, 5);
        wr(CFG_V_RES, 8);  wr(CFG_V_FP, 1); wr(CFG_V_SYNC, 2); wr(CFG_V_BP, 3);
        wr(CFG_POL, 3);
        commit();
        check("pend_set", 40'(cfg_if.cfg_pending), 40'd1);
        wait_frame();
        check("pend_clr", 40'(cfg_if.cfg_pending), 40'd0);
        clr_stats();
        run(448);
        check("new_frames", 40'(cnt_fr), 40'd1);
        check("new_de", 40'(cnt_de), 40'd160);
        check("new_hs_high", 40'(cnt_hhi), 40'd56);

        // Commit on the boundary cycle takes effect one frame later
        wr(CFG_H_SYNC, 6);
        for (int n = 0; n < 2000 && !(mx == act[0] - 1 && my == act[4] - 1); n++) step();
        commit();
        check("bnd_pend", 40'(cfg_if.cfg_pending), 40'd1);
        wait_frame();
        check("bnd_pend_hold", 40'(cfg_if.cfg_pending), 40'd1);
        clr_stats();
        run(448);
        check("bnd_old_frame", 40'(cnt_fr), 40'd1);
        check("bnd_pend_clr", 40'(cfg_if.cfg_pending), 40'd0);
        clr_stats();
        run(476);
        check("bnd_new_hs_high", 40'(cnt_hhi), 40'd84);

        // Rejected commit: H_RES staged as zero
        wr(CFG_H_RES, 0);
        commit();
        check("err_pulse", 40'(cfg_if.cfg_err), 40'd1);
        check("err_no_pend", 40'(cfg_if.cfg_pending), 40'd0);
        step();
        check("err_one_cycle", 40'(cfg_if.cfg_err), 40'd0);
        wr(CFG_H_RES, 20);

        // EARLY = 8: one pre-pulse per active line at sx = -8
        wr(CFG_EARLY, 8);
        commit();
        wait_frame();
        clr_stats();
        run(476);
        check("early8_count", 40'(cnt_lp), 40'd8);
        check("early8_pos", 40'(cnt_lp_badx), 40'd0);

        // EARLY beyond blanking clamps onto the line pulse
        wr(CFG_EARLY, 500);
        commit();
        wait_frame();
        clr_stats();
        run(476);
        check("early500_count", 40'(cnt_lp), 40'd8);
        check("early500_eq_line", 40'(cnt_lp_ne_ln), 40'd0);

        // Reset with a pending commit mid-line
        wr(CFG_H_RES, 32);
        commit();
        run(5);
        check("rst_pend_before", 40'(cfg_if.cfg_pending), 40'd1);
        rst = 1'b1;
        step();
        check("rst_pend_after", 40'(cfg_if.cfg_pending), 40'd0);
        check("rst2_sx", 40'(sx), 40'(16'(-9)));
        check("rst2_ctl", 40'({hsync, vsync, de, frame, line, line_pre}), 40'b110000);
        step();
        rst = 1'b0;
        clr_stats();
        run(250);
        check("rst2_frames", 40'(cnt_fr), 40'd1);
        check("rst2_de", 40'(cnt_de), 40'd96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
